// File: rtl/lms_ctr_spi_slave_pkg.sv
// lms_ctr_spi_slave_pkg: register map, status bit positions and shared types
// for the LMS control-bus SPI slave.
package lms_ctr_spi_slave_pkg;

  localparam int DATABITS_DEFAULT = 8;

  // CPU register addresses
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

  // Status word bit positions; the control word uses the same positions
  localparam int ST_EOP  = 9;
  localparam int ST_E    = 8;
  localparam int ST_RRDY = 7;
  localparam int ST_TRDY = 6;
  localparam int ST_TMT  = 5;
  localparam int ST_TOE  = 4;
  localparam int ST_ROE  = 3;
  localparam int ST_TUR  = 2;

  // Frame engine state: idle while deselected, busy between SS_n edges
  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_BUSY = 1'b1
  } frame_state_t;

endpackage

// File: rtl/lms_ctr_spi_slave_if.sv
// lms_ctr_spi_slave_if: memory-mapped CPU register port of the SPI slave.
interface lms_ctr_spi_slave_if;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        dataavailable;
  logic        readyfordata;
  logic        endofpacket;
  logic        irq;

  modport master (
    output spi_select, mem_addr, read_n, write_n, data_from_cpu,
    input  data_to_cpu, dataavailable, readyfordata, endofpacket, irq
  );

  modport slave (
    input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
    output data_to_cpu, dataavailable, readyfordata, endofpacket, irq
  );
endinterface

// File: rtl/lms_ctr_spi_slave_sync.sv
// lms_ctr_spi_slave_sync: STAGES-deep synchroniser for an SPI pin, followed
// by one edge-detect register producing single-cycle rise/fall pulses.
module lms_ctr_spi_slave_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  // Shift the pin through the synchroniser and remember the previous level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_reg <= {STAGES{RESET_VAL}};
      prev_reg  <= RESET_VAL;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], din};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign level = chain_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/lms_ctr_spi_slave.sv
// lms_ctr_spi_slave: SPI mode-0 slave with CPU register port.
// Optional feature macro: LMS_SPI_SLAVE_EOP_EN (end-of-packet register at
// addr 6 and the EOP status flag). Without it EOP is tied low.
module lms_ctr_spi_slave
  import lms_ctr_spi_slave_pkg::*;
#(
  parameter int DATABITS    = DATABITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic SCLK,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO,
  output logic MISO_oe,
  lms_ctr_spi_slave_if.slave cpu
);

  localparam int CNT_W = $clog2(DATABITS + 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  lms_ctr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(SCLK),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

  // SS_n idles high, so its synchroniser resets high to keep MISO_oe low
  lms_ctr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .din(SS_n),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall));

  lms_ctr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(MOSI),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  frame_state_t        state_reg;
  logic [CNT_W-1:0]    bitcnt_reg;
  logic [DATABITS-2:0] rx_shift_reg;
  logic [DATABITS-1:0] tx_shift_reg, tx_holding_reg, rx_holding_reg;
  logic [DATABITS-1:0] rx_byte, tx_next;
  logic                tx_primed_reg, rrdy_reg, roe_reg, toe_reg, tur_reg, eop_flag;
  logic [7:0]          ctrl_reg;
  logic                wr_prev_reg, rd_prev_reg;
  logic                wr_req, rd_req, wr_stb, rd_stb;
  logic                wr_tx, wr_status, wr_ctrl, rd_rx;
  logic                busy, last_bit, rx_done, tx_load;
  logic [15:0]         status_word, rd_mux;
  logic                cpu_data_unused;

  assign busy     = (state_reg == FRAME_BUSY);
  assign last_bit = (bitcnt_reg == CNT_W'(DATABITS - 1));
  assign rx_byte  = {rx_shift_reg, mosi_level};
  assign tx_next  = tx_primed_reg ? tx_holding_reg : '0;

  // Frame events; SS_n edges take priority over SCLK edges in the same cycle
  assign rx_done = busy & ~ss_fall & ~ss_rise & sclk_rise & last_bit;
  assign tx_load = ss_fall | (busy & ~ss_rise & sclk_fall & (bitcnt_reg == '0));

  // One strobe per CPU access: only the first cycle of a held request counts
  assign wr_req    = cpu.spi_select & ~cpu.write_n;
  assign rd_req    = cpu.spi_select & ~cpu.read_n;
  assign wr_stb    = wr_req & ~wr_prev_reg;
  assign rd_stb    = rd_req & ~rd_prev_reg;
  assign wr_tx     = wr_stb & (cpu.mem_addr == ADDR_TXDATA);
  assign wr_status = wr_stb & (cpu.mem_addr == ADDR_STATUS);
  assign wr_ctrl   = wr_stb & (cpu.mem_addr == ADDR_CONTROL);
  assign rd_rx     = rd_stb & (cpu.mem_addr == ADDR_RXDATA);
  assign cpu_data_unused = ^{cpu.data_from_cpu[15:10], cpu.data_from_cpu[1:0]};

`ifdef LMS_SPI_SLAVE_EOP_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
  logic [DATABITS-1:0] eop_val_reg;
  logic                eop_reg;
  logic                eop_set;

  assign eop_set = (rx_done & (rx_byte == eop_val_reg)) |
                   (wr_tx & (cpu.data_from_cpu[DATABITS-1:0] == eop_val_reg));

  // End-of-packet match value and sticky EOP flag (a new match beats a clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eop_val_reg <= '0;
      eop_reg     <= 1'b0;
    end else begin
      if (wr_stb && cpu.mem_addr == ADDR_EOPVAL)
        eop_val_reg <= cpu.data_from_cpu[DATABITS-1:0];
      eop_reg <= (eop_reg & ~wr_status) | eop_set;
    end
  end
  assign eop_flag = eop_reg;
`else
  localparam logic [7:0] CTRL_MASK = 8'h7F;
  assign eop_flag = 1'b0;
`endif

  // Frame engine: SS_n framing, bit counting, RX assembly and TX shifting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= FRAME_IDLE;
      bitcnt_reg   <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      MISO         <= 1'b0;
    end else begin
      MISO <= tx_shift_reg[DATABITS-1];
      if (ss_fall) begin
        state_reg    <= FRAME_BUSY;
        bitcnt_reg   <= '0;
        tx_shift_reg <= tx_next;
      end else if (ss_rise) begin
        state_reg  <= FRAME_IDLE;
        bitcnt_reg <= '0;
      end else if (busy) begin
        if (sclk_rise) begin
          rx_shift_reg <= rx_byte[DATABITS-2:0];
          bitcnt_reg   <= last_bit ? '0 : bitcnt_reg + CNT_W'(1);
        end
        if (sclk_fall) begin
          if (bitcnt_reg != '0) tx_shift_reg <= {tx_shift_reg[DATABITS-2:0], 1'b0};
          else                  tx_shift_reg <= tx_next;
        end
      end
    end
  end

  // Holding registers and sticky status flags; a set beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_holding_reg <= '0;
      tx_holding_reg <= '0;
      tx_primed_reg  <= 1'b0;
      rrdy_reg       <= 1'b0;
      roe_reg        <= 1'b0;
      toe_reg        <= 1'b0;
      tur_reg        <= 1'b0;
      ctrl_reg       <= '0;
    end else begin
      if (rx_done) rx_holding_reg <= rx_byte;
      if (wr_tx && !tx_primed_reg) begin
        tx_holding_reg <= cpu.data_from_cpu[DATABITS-1:0];
        tx_primed_reg  <= 1'b1;
      end else if (tx_load) begin
        tx_primed_reg <= 1'b0;
      end
      if (rx_done)    rrdy_reg <= 1'b1;
      else if (rd_rx) rrdy_reg <= 1'b0;
      roe_reg <= (roe_reg & ~wr_status) | (rx_done & rrdy_reg & ~rd_rx);
      toe_reg <= (toe_reg & ~wr_status) | (wr_tx & tx_primed_reg);
      tur_reg <= (tur_reg & ~wr_status) | (tx_load & ~tx_primed_reg);
      if (wr_ctrl) ctrl_reg <= cpu.data_from_cpu[9:2] & CTRL_MASK;
    end
  end

  // Assemble the status word from the live flags
  always_comb begin
    status_word          = '0;
    status_word[ST_EOP]  = eop_flag;
    status_word[ST_E]    = roe_reg | toe_reg | tur_reg;
    status_word[ST_RRDY] = rrdy_reg;
    status_word[ST_TRDY] = ~tx_primed_reg;
    status_word[ST_TMT]  = ~busy & ~tx_primed_reg;
    status_word[ST_TOE]  = toe_reg;
    status_word[ST_ROE]  = roe_reg;
    status_word[ST_TUR]  = tur_reg;
  end

  // Read-data multiplexer; unmapped addresses return 0
  always_comb begin
    rd_mux = '0;
    case (cpu.mem_addr)
      ADDR_RXDATA:  rd_mux = 16'(rx_holding_reg);
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_CONTROL: rd_mux = {6'b0, ctrl_reg, 2'b0};
`ifdef LMS_SPI_SLAVE_EOP_EN
      ADDR_EOPVAL:  rd_mux = 16'(eop_val_reg);
`endif
      default:      rd_mux = '0;
    endcase
  end

  // Registered CPU outputs and strobe edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_reg     <= 1'b0;
      rd_prev_reg     <= 1'b0;
      cpu.data_to_cpu <= '0;
      cpu.irq         <= 1'b0;
    end else begin
      wr_prev_reg     <= wr_req;
      rd_prev_reg     <= rd_req;
      cpu.data_to_cpu <= rd_mux;
      cpu.irq         <= |(status_word[ST_EOP:ST_TUR] & ctrl_reg);
    end
  end

  assign MISO_oe           = ~ss_level;
  assign cpu.dataavailable = rrdy_reg;
  assign cpu.readyfordata  = ~tx_primed_reg;
  assign cpu.endofpacket   = eop_flag;

endmodule

// File: tb/tb_lms_ctr_spi_slave.sv
// tb_lms_ctr_spi_slave: directed bench for the SPI slave. A table of single
// frames checks the basic path; hand-written sequences cover back-to-back
// frames, underrun, overrun, abort, TOE/irq and the end-of-packet option.
`timescale 1ns/1ps
module tb_lms_ctr_spi_slave;
  import lms_ctr_spi_slave_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic SCLK = 1'b0;
  logic MOSI = 1'b0;
  logic SS_n = 1'b1;
  logic MISO, MISO_oe;

  lms_ctr_spi_slave_if bus();

  lms_ctr_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
    .MISO(MISO), .MISO_oe(MISO_oe), .cpu(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  tx;
    logic [7:0]  mosi;
    logic [7:0]  exp_miso;
    logic [15:0] exp_rx;
    logic [15:0] exp_st_frame;
    logic [15:0] exp_st_read;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    bus.spi_select = 1'b1; bus.write_n = 1'b0; bus.mem_addr = a; bus.data_from_cpu = d;
    tick(1);
    bus.write_n = 1'b1; bus.spi_select = 1'b0;
    tick(1);
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    bus.spi_select = 1'b1; bus.read_n = 1'b0; bus.mem_addr = a;
    tick(1);
    d = bus.data_to_cpu;
    bus.read_n = 1'b1; bus.spi_select = 1'b0;
    tick(1);
  endtask

  task automatic ss_low();
    SS_n = 1'b0;
    tick(4);
  endtask

  task automatic ss_high();
    tick(4);
    SS_n = 1'b1;
    tick(4);
  endtask

  // Mode-0 master, SCLK = clk/8; MISO sampled just before each rising edge
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = mo[7-i];
      tick(4);
      mi[7-i] = MISO;
      SCLK = 1'b1;
      tick(4);
      SCLK = 1'b0;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [15:0] d;
    logic [7:0] m1, m2;

    // tx, mosi, miso, rx, status after frame (TUR from end-of-frame reload), after rx read
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 16'h003C, 16'h01E4, 16'h0164};
    vecs[1] = '{8'h0F, 8'hF0, 8'h0F, 16'h00F0, 16'h01E4, 16'h0164};
    vecs[2] = '{8'hFF, 8'h80, 8'hFF, 16'h0080, 16'h01E4, 16'h0164};
    vecs[3] = '{8'h81, 8'h18, 8'h81, 16'h0018, 16'h01E4, 16'h0164};

    bus.spi_select = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.mem_addr = 3'd0; bus.data_from_cpu = 16'h0000;

    // Reset values
    tick(3);
    check("rst_data_to_cpu", bus.data_to_cpu, 16'h0000);
    check("rst_dataavailable", 16'(bus.dataavailable), 16'h0000);
    check("rst_readyfordata", 16'(bus.readyfordata), 16'h0001);
    check("rst_endofpacket", 16'(bus.endofpacket), 16'h0000);
    check("rst_irq", 16'(bus.irq), 16'h0000);
    check("rst_miso", 16'(MISO), 16'h0000);
    check("rst_miso_oe", 16'(MISO_oe), 16'h0000);
    reset_n = 1'b1;
    tick(2);
    cpu_read(ADDR_STATUS, d);
    check("rst_status", d, 16'h0060);

    // Table of single frames
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      cpu_write(ADDR_TXDATA, {8'h00, v.tx});
      check("vec_trdy_primed", 16'(bus.readyfordata), 16'h0000);
      ss_low();
      spi_bits(v.mosi, 8, m1);
      ss_high();
      check("vec_miso", 16'(m1), 16'(v.exp_miso));
      check("vec_rrdy_out", 16'(bus.dataavailable), 16'h0001);
      cpu_read(ADDR_STATUS, d);
      check("vec_status_frame", d, v.exp_st_frame);
      cpu_read(ADDR_RXDATA, d);
      check("vec_rx", d, v.exp_rx);
      cpu_read(ADDR_STATUS, d);
      check("vec_status_read", d, v.exp_st_read);
      $display("vector %0d: tx=%02h mosi=%02h miso=%02h rx=%04h", i, v.tx, v.mosi, m1, v.exp_rx);
      cpu_write(ADDR_STATUS, 16'h0000);
    end

    // Back-to-back frames with refill; second frame unread -> ROE
    cpu_write(ADDR_TXDATA, 16'h00A5);
    ss_low();
    check("b2b_miso_oe", 16'(MISO_oe), 16'h0001);
    cpu_write(ADDR_TXDATA, 16'h005A);
    spi_bits(8'h11, 8, m1);
    spi_bits(8'h22, 8, m2);
    ss_high();
    check("b2b_miso_oe_off", 16'(MISO_oe), 16'h0000);
    check("b2b_miso1", 16'(m1), 16'h00A5);
    check("b2b_miso2", 16'(m2), 16'h005A);
    cpu_read(ADDR_STATUS, d);
    check("b2b_status_roe", d, 16'h01EC);
    cpu_write(ADDR_STATUS, 16'h0000);
    cpu_read(ADDR_STATUS, d);
    check("b2b_status_cleared", d, 16'h00E0);
    cpu_read(ADDR_RXDATA, d);
    check("b2b_rx_second", d, 16'h0022);
    cpu_read(ADDR_STATUS, d);
    check("b2b_status_read", d, 16'h0060);
    $display("back-to-back: miso %02h %02h", m1, m2);

    // Back-to-back without refill -> underrun sends 0x00
    cpu_write(ADDR_TXDATA, 16'h003C);
    ss_low();
    spi_bits(8'h44, 8, m1);
    spi_bits(8'h55, 8, m2);
    ss_high();
    check("tur_miso1", 16'(m1), 16'h003C);
    check("tur_miso2", 16'(m2), 16'h0000);
    cpu_read(ADDR_STATUS, d);
    check("tur_status", d, 16'h01EC);
    cpu_read(ADDR_RXDATA, d);
    check("tur_rx", d, 16'h0055);
    cpu_write(ADDR_STATUS, 16'h0000);
    cpu_read(ADDR_STATUS, d);
    check("tur_status_clear", d, 16'h0060);
    $display("underrun: miso %02h %02h", m1, m2);

    // Abort after 5 bits: nothing received
    ss_low();
    spi_bits(8'h99, 5, m1);
    ss_high();
    check("abort_rrdy", 16'(bus.dataavailable), 16'h0000);
    cpu_read(ADDR_STATUS, d);
    check("abort_status", d, 16'h0164);
    cpu_read(ADDR_RXDATA, d);
    check("abort_rx_kept", d, 16'h0055);
    cpu_write(ADDR_STATUS, 16'h0000);
    cpu_write(ADDR_TXDATA, 16'h00C3);
    ss_low();
    spi_bits(8'h96, 8, m1);
    ss_high();
    check("after_abort_miso", 16'(m1), 16'h00C3);
    cpu_read(ADDR_RXDATA, d);
    check("after_abort_rx", d, 16'h0096);
    cpu_write(ADDR_STATUS, 16'h0000);
    $display("abort: next frame rx=%04h", d);

    // Held write strobe fires once: no TOE
    bus.spi_select = 1'b1; bus.write_n = 1'b0; bus.mem_addr = ADDR_TXDATA; bus.data_from_cpu = 16'h0044;
    tick(3);
    bus.write_n = 1'b1; bus.spi_select = 1'b0;
    tick(1);
    cpu_read(ADDR_STATUS, d);
    check("held_write_status", d, 16'h0000);
    ss_low();
    spi_bits(8'h33, 8, m1);
    ss_high();
    check("held_write_miso", 16'(m1), 16'h0044);
    cpu_read(ADDR_RXDATA, d);
    check("held_write_rx", d, 16'h0033);
    cpu_write(ADDR_STATUS, 16'h0000);
    $display("held write: miso=%02h", m1);

    // TOE with interrupt enabled on bit 4
    cpu_write(ADDR_CONTROL, 16'h0010);
    cpu_read(ADDR_CONTROL, d);
    check("ctrl_readback", d, 16'h0010);
    check("irq_idle", 16'(bus.irq), 16'h0000);
    cpu_write(ADDR_TXDATA, 16'h00A1);
    bus.spi_select = 1'b1; bus.write_n = 1'b0; bus.mem_addr = ADDR_TXDATA; bus.data_from_cpu = 16'h00B2;
    tick(1);
    check("toe_irq_lag", 16'(bus.irq), 16'h0000);
    bus.write_n = 1'b1; bus.spi_select = 1'b0;
    tick(1);
    check("toe_irq", 16'(bus.irq), 16'h0001);
    cpu_read(ADDR_STATUS, d);
    check("toe_status", d, 16'h0110);
    ss_low();
    spi_bits(8'h5C, 8, m1);
    ss_high();
    check("toe_holding_kept", 16'(m1), 16'h00A1);
    cpu_write(ADDR_STATUS, 16'h0000);
    check("toe_irq_cleared", 16'(bus.irq), 16'h0000);
    cpu_read(ADDR_RXDATA, d);
    cpu_write(ADDR_CONTROL, 16'h0000);
    $display("toe: miso=%02h", m1);

    // End-of-packet option
`ifdef LMS_SPI_SLAVE_EOP_EN
    cpu_write(ADDR_EOPVAL, 16'h007E);
    cpu_read(ADDR_EOPVAL, d);
    check("eop_val_readback", d, 16'h007E);
    check("eop_idle", 16'(bus.endofpacket), 16'h0000);
    cpu_write(ADDR_TXDATA, 16'h003A);
    ss_low();
    spi_bits(8'h7E, 8, m1);
    ss_high();
    check("eop_set", 16'(bus.endofpacket), 16'h0001);
    cpu_read(ADDR_STATUS, d);
    check("eop_status_bit", 16'(d[ST_EOP]), 16'h0001);
    cpu_read(ADDR_RXDATA, d);
    check("eop_rx", d, 16'h007E);
    cpu_write(ADDR_STATUS, 16'h0000);
    check("eop_cleared", 16'(bus.endofpacket), 16'h0000);
    cpu_write(ADDR_CONTROL, 16'hFFFF);
    cpu_read(ADDR_CONTROL, d);
    check("ctrl_mask", d, 16'h03FC);
`else
    cpu_write(ADDR_EOPVAL, 16'h007E);
    cpu_read(ADDR_EOPVAL, d);
    check("eop_addr_reads_zero", d, 16'h0000);
    ss_low();
    spi_bits(8'h7E, 8, m1);
    ss_high();
    check("eop_tied_low", 16'(bus.endofpacket), 16'h0000);
    cpu_read(ADDR_RXDATA, d);
    check("eop_rx", d, 16'h007E);
    cpu_write(ADDR_CONTROL, 16'hFFFF);
    cpu_read(ADDR_CONTROL, d);
    check("ctrl_mask", d, 16'h01FC);
`endif
    cpu_write(ADDR_CONTROL, 16'h0000);
    $display("eop: rx=%04h endofpacket=%0d", 16'h007E, bus.endofpacket);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
